// File: rtl/stream_width_packer.sv
// stream_width_packer
// Gathers RATIO consecutive BIT_WIDTH-bit words into one wide word. The first
// word of a group goes in lane 0 (little-endian). A word marked in_last closes
// the group early. out_count reports how many lanes of out_data are valid, and
// the unused upper lanes are zero.
module stream_width_packer #(
    parameter int BIT_WIDTH = 32,
    parameter int RATIO     = 4,
    parameter int CNT_W     = $clog2(RATIO + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIT_WIDTH-1:0]       in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_WIDTH*RATIO-1:0] out_data,
    output logic [CNT_W-1:0]           out_count,
    output logic                       out_last
);

    localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef logic [RATIO-1:0][BIT_WIDTH-1:0] lanes_t;

    // Partially packed group
    lanes_t              acc_q, acc_d;
    logic [LANE_W-1:0]   cnt_q, cnt_d;

    // Output holding register
    lanes_t              out_data_q, out_data_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    logic                in_fire;
    logic                last_lane;
    logic                completing;
    lanes_t              packed_word;

    // The packer can take a word whenever the output register is empty or is
    // being drained on this same edge.
    assign in_ready   = !out_valid_q || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign last_lane  = (cnt_q == LANE_W'(RATIO - 1));
    assign completing = in_fire && (last_lane || in_last);

    // Merge the accumulated lanes with the incoming word; lanes above cnt are zero.
    always_comb begin
        packed_word = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) < cnt_q) begin
                packed_word[i] = acc_q[i];
            end else if (LANE_W'(i) == cnt_q) begin
                packed_word[i] = in_data;
            end
        end
    end

    // Accumulator and lane counter: append on a plain beat, clear on a completing beat.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (completing) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_fire) begin
            acc_d[cnt_q] = in_data;
            cnt_d        = cnt_q + LANE_W'(1);
        end
    end

    // Output register: drain on handshake, reload on a completing beat (a reload
    // in the same edge as a drain keeps out_valid high for back-to-back words).
    always_comb begin
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !out_ready;
        if (completing) begin
            out_data_d  = packed_word;
            out_count_d = CNT_W'(cnt_q) + CNT_W'(1);
            out_last_d  = in_last;
            out_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/stream_width_packer.md
Name: stream_width_packer

Overview:
- Sits between the file-reader stimulus source and the collector sink in the BIT_WIDTH streaming testbench flow.
- Consumes a stream of BIT_WIDTH-bit words (the words the reader emits from the input .bin file).
- Packs every RATIO consecutive words into one wide word for the downstream consumer, or fewer words when the packet ends early.
- Flushes partial words on a last marker and reports how many lanes in the wide word are valid.

Parameters:
- BIT_WIDTH, 32, width of one input word.
- RATIO, 4, input words per output word; integer >= 2.
- CNT_W, $clog2(RATIO+1), width of the lane-count output (derived; do not override).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  packer can accept a word.
- in_data  input  BIT_WIDTH  input word.
- in_last  input  1  word is the final word of a packet.
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts the packed word.
- out_data  output  BIT_WIDTH*RATIO  packed word.
- out_count  output  CNT_W  number of valid lanes in out_data, range 1..RATIO.
- out_last  output  1  packed word closes a packet.

Behaviour:
- Handshake (both sides): a transfer occurs on a rising edge with valid && ready.
  - valid, once high, holds with stable payload until the transfer.
  - in_ready = !out_valid || out_ready. This is combinational from out_ready; there is no other path from in_* to in_ready.
- Lane order (little-endian):
  - The first accepted word of a group goes to out_data[BIT_WIDTH-1:0].
  - Lane k goes to bits [(k+1)*BIT_WIDTH-1 : k*BIT_WIDTH].
  - This matches the byte order of the .bin files.
- State:
  - Accumulator register of RATIO lanes.
  - Lane counter cnt in 0..RATIO-1.
  - Output register holding out_data, out_count, out_last and out_valid.
- Accepting a word when cnt < RATIO-1 and in_last = 0: write the word to lane cnt; cnt increments.
- Completing word: an accepted word with cnt == RATIO-1 or in_last = 1.
  - out_data gets the accumulator lanes 0..cnt-1, the incoming word in lane cnt, and zeros in lanes above cnt.
  - out_count = cnt+1, out_last = in_last, out_valid = 1.
  - cnt returns to 0 and the accumulator clears.
  - All of this in the same edge.
- Latency: out_valid rises in the cycle after the completing handshake. There is no other pipeline delay.
- Output transfer with no new completing word: out_valid drops to 0 on the next edge. out_data, out_count and out_last hold their last values.
- Simultaneous output transfer and completing input word: the output register reloads with the new word and out_valid stays 1. This gives full throughput of one wide word per RATIO input cycles with no bubbles.
- Backpressure:
  - While out_valid = 1 and out_ready = 0, in_ready = 0.
  - The accumulator and cnt do not change.
  - out_* stay stable.
- in_last on lane 0: produces out_count = 1 and out_last = 1, with lanes 1..RATIO-1 zero.
- Reset (rst_n = 0 at an edge, including mid-word or mid-stall):
  - out_valid = 0, out_data = 0, out_count = 0, out_last = 0.
  - cnt = 0, accumulator = 0.
  - Partially packed lanes and any unaccepted output word are discarded.
  - in_ready reads 1 during and after reset, since it follows out_valid = 0.
- No overflow or underflow is possible. cnt saturates by construction because a completing word always resets it.

Test Plan (BIT_WIDTH=8, RATIO=4 unless stated):
- Full word: beats 0x11, 0x22, 0x33, 0x44 with out_ready = 1 -> one cycle after the 4th handshake, out_data = 0x44332211, out_count = 4, out_last = 0, held for one cycle.
- Partial flush: 6 beats 0x11..0x66 with in_last on the 6th -> 0x44332211 (count 4, last 0), then 0x00006655 (count 2, last 1).
- Single-beat packet: 0xAA with in_last -> out_data = 0x000000AA, out_count = 1, out_last = 1.
- Backpressure: complete a word, hold out_ready = 0 for 5 cycles -> in_ready = 0 for those 5 cycles, out_data stable, no beat lost. Release -> the next group packs correctly.
- Throughput: 16 back-to-back beats 0x00..0x0F with out_ready = 1 -> 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive-group cycles, and in_ready never drops.
- Reset mid-word: 2 beats accepted, then rst_n = 0 for 1 cycle -> all outputs 0. Next 4 beats 0xA1..0xA4 give 0xA4A3A2A1 with count 4.
